apb_cmd_master: RTL and testbench



---
 rtl/apb_pkg.sv | 20 ++
 rtl/apb_wait_timer.sv | 39 +++
 rtl/apb_cmd_master.sv | 171 +++++++++++++++++
 tb/tb_apb_cmd_master.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared state encoding and parameter helpers for the APB command master
package apb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } apb_state_t;

   function automatic bit apb_params_ok(input int addr_w, input int data_w);
      return (addr_w >= 8) && (addr_w <= 32) &&
             ((data_w == 8) || (data_w == 16) || (data_w == 32));
   endfunction

   function automatic int apb_strb_w(input int data_w);
      return data_w / 8;
   endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// rtl/apb_wait_timer.sv - saturating ACCESS wait counter; expire flags the last allowed wait cycle
module apb_wait_timer #(
   parameter int TIMEOUT_CYC = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic en,
   output logic expire
);

   localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
   localparam bit TMO_EN = (TIMEOUT_CYC > 0);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYC > 0) ? (TIMEOUT_CYC - 1) : 0);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (en && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire = TMO_EN && (cnt_q == CNT_LAST);

endmodule

// File: rtl/apb_cmd_master.sv
// rtl/apb_cmd_master.sv - valid/ready command and response ports bridged onto one APB4 completer
module apb_cmd_master
   import apb_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int TIMEOUT_CYC = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_W-1:0]     cmd_addr,
   input  logic [DATA_W-1:0]     cmd_wdata,
   input  logic [DATA_W/8-1:0]   cmd_strb,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_W-1:0]     rsp_rdata,
   output logic                  rsp_err,
   output logic                  rsp_timeout,
   output logic                  psel,
   output logic                  penable,
   output logic                  pwrite,
   output logic [ADDR_W-1:0]     paddr,
   output logic [DATA_W-1:0]     pwdata,
   output logic [DATA_W/8-1:0]   pstrb,
   input  logic [DATA_W-1:0]     prdata,
   input  logic                  pready,
   input  logic                  pslverr
);

   localparam int STRB_W = apb_strb_w(DATA_W);
   localparam int LSB    = $clog2(STRB_W);
   localparam logic [ADDR_W-1:0] ALIGN_MASK = {ADDR_W{1'b1}} << LSB;

   if (!apb_params_ok(ADDR_W, DATA_W)) begin : g_bad_params
      $error("apb_cmd_master: unsupported ADDR_W/DATA_W");
   end

   apb_state_t          state_q, state_d;
   logic                psel_q, psel_d;
   logic                penable_q, penable_d;
   logic                pwrite_q, pwrite_d;
   logic [ADDR_W-1:0]   paddr_q, paddr_d;
   logic [DATA_W-1:0]   pwdata_q, pwdata_d;
   logic [STRB_W-1:0]   pstrb_q, pstrb_d;
   logic                rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
   logic                rsp_err_q, rsp_err_d;
   logic                rsp_timeout_q, rsp_timeout_d;
   logic                timer_clear;
   logic                timer_en;
   logic                timer_expire;

   apb_wait_timer #(
      .TIMEOUT_CYC(TIMEOUT_CYC)
   ) u_wait_timer (
      .clk   (clk),
      .rst   (rst),
      .clear (timer_clear),
      .en    (timer_en),
      .expire(timer_expire)
   );

   always_comb begin
      state_d       = state_q;
      psel_d        = psel_q;
      penable_d     = penable_q;
      pwrite_d      = pwrite_q;
      paddr_d       = paddr_q;
      pwdata_d      = pwdata_q;
      pstrb_d       = pstrb_q;
      rsp_valid_d   = rsp_valid_q;
      rsp_rdata_d   = rsp_rdata_q;
      rsp_err_d     = rsp_err_q;
      rsp_timeout_d = rsp_timeout_q;
      timer_clear   = 1'b0;
      timer_en      = 1'b0;
      case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               paddr_d   = cmd_addr & ALIGN_MASK;
               pwrite_d  = cmd_write;
               pwdata_d  = cmd_write ? cmd_wdata : '0;
               pstrb_d   = cmd_write ? cmd_strb : '0;
               psel_d    = 1'b1;
               penable_d = 1'b0;
               state_d   = SETUP;
            end
         end
         SETUP: begin
            penable_d   = 1'b1;
            timer_clear = 1'b1;
            state_d     = ACCESS;
         end
         ACCESS: begin
            if (pready) begin
               rsp_rdata_d   = pwrite_q ? '0 : prdata;
               rsp_err_d     = pslverr;
               rsp_timeout_d = 1'b0;
               rsp_valid_d   = 1'b1;
               psel_d        = 1'b0;
               penable_d     = 1'b0;
               state_d       = RESP;
            end else if (timer_expire) begin
               // last allowed wait cycle passed without pready: abort the transfer
               rsp_rdata_d   = '0;
               rsp_err_d     = 1'b1;
               rsp_timeout_d = 1'b1;
               rsp_valid_d   = 1'b1;
               psel_d        = 1'b0;
               penable_d     = 1'b0;
               state_d       = RESP;
            end else begin
               timer_en = 1'b1;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         psel_q        <= 1'b0;
         penable_q     <= 1'b0;
         pwrite_q      <= 1'b0;
         paddr_q       <= '0;
         pwdata_q      <= '0;
         pstrb_q       <= '0;
         rsp_valid_q   <= 1'b0;
         rsp_rdata_q   <= '0;
         rsp_err_q     <= 1'b0;
         rsp_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         psel_q        <= psel_d;
         penable_q     <= penable_d;
         pwrite_q      <= pwrite_d;
         paddr_q       <= paddr_d;
         pwdata_q      <= pwdata_d;
         pstrb_q       <= pstrb_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_rdata_q   <= rsp_rdata_d;
         rsp_err_q     <= rsp_err_d;
         rsp_timeout_q <= rsp_timeout_d;
      end
   end

   assign cmd_ready   = (state_q == IDLE) && !rst;
   assign psel        = psel_q;
   assign penable     = penable_q;
   assign pwrite      = pwrite_q;
   assign paddr       = paddr_q;
   assign pwdata      = pwdata_q;
   assign pstrb       = pstrb_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_rdata   = rsp_rdata_q;
   assign rsp_err     = rsp_err_q;
   assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
// tb/tb_apb_cmd_master.sv - scoreboard bench for apb_cmd_master with an APB completer model
module tb_apb_cmd_master;

   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int SW  = 4;
   localparam int TMO = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          cmd_valid, cmd_ready, cmd_write;
   logic [AW-1:0] cmd_addr;
   logic [DW-1:0] cmd_wdata;
   logic [SW-1:0] cmd_strb;
   logic          rsp_valid, rsp_ready, rsp_err, rsp_timeout;
   logic [DW-1:0] rsp_rdata;
   logic          psel, penable, pwrite;
   logic [AW-1:0] paddr;
   logic [DW-1:0] pwdata;
   logic [SW-1:0] pstrb;
   logic [DW-1:0] prdata;
   logic          pready, pslverr;

   apb_cmd_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TMO)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
      .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
      .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata), .pready(pready),
      .pslverr(pslverr)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;

   typedef struct { logic [31:0] rdata; logic err; logic tmo; int lat; } exp_t;
   typedef struct { int w; logic err; logic [31:0] rdata; } plan_t;
   typedef struct { logic [31:0] addr; logic wr; logic [31:0] wdata; logic [3:0] strb; int setup_cyc; } apb_t;

   exp_t  exp_q[$];
   plan_t plan_q[$];
   apb_t  apb_q[$];
   int    pen_rise = 0;
   int    rr_mode  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
      end
   endtask

   // reference: pready comes after w low ACCESS cycles; TMO low cycles abort the transfer
   function automatic exp_t model(input bit wr, input plan_t p);
      exp_t e;
      if (p.w >= TMO) begin
         e.rdata = 0; e.err = 1'b1; e.tmo = 1'b1; e.lat = TMO;
      end else begin
         e.rdata = wr ? 32'h0 : p.rdata; e.err = p.err; e.tmo = 1'b0; e.lat = p.w + 1;
      end
      return e;
   endfunction

   task automatic do_cmd(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb, input plan_t p);
      int   n;
      apb_t a;
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata; cmd_strb = strb;
      n = 0;
      @(negedge clk);
      while (!cmd_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (!cmd_ready) begin
         chk("cmd_accept_wait", 32'd0, 32'd1);
         cmd_valid = 1'b0;
         return;
      end
      chk("no_outstanding_rsp_at_accept", exp_q.size(), 0);
      a.addr = addr & 32'hFFFF_FFFC; a.wr = wr;
      a.wdata = wr ? wdata : 32'h0; a.strb = wr ? strb : 4'h0;
      a.setup_cyc = cyc + 1;
      apb_q.push_back(a);
      plan_q.push_back(p);
      exp_q.push_back(model(wr, p));
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      cmd_write = 1'($urandom); cmd_addr = $urandom; cmd_wdata = $urandom; cmd_strb = 4'($urandom);
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 500) begin
         @(posedge clk);
         n++;
      end
      chk("drain_pending", exp_q.size(), 0);
      @(posedge clk);
      #1;
   endtask

   function automatic plan_t mk(input int w, input logic err, input logic [31:0] rd);
      plan_t p;
      p.w = w; p.err = err; p.rdata = rd;
      return p;
   endfunction

   // APB completer: pready after the planned number of wait cycles, noise elsewhere
   initial begin : completer
      int    acc;
      plan_t pl;
      apb_t  cur;
      acc = 0; pl = mk(0, 1'b0, 32'h0);
      cur.addr = 0; cur.wr = 0; cur.wdata = 0; cur.strb = 0; cur.setup_cyc = 0;
      pready = 1'b0; pslverr = 1'b0; prdata = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            acc = 0; pready = 1'b0;
         end else if (psel && !penable) begin
            if (apb_q.size() == 0) begin
               chk("setup_unexpected", 32'd1, 32'd0);
            end else begin
               cur = apb_q.pop_front();
               chk("setup_cycle", cyc, cur.setup_cyc);
               chk("setup_paddr", paddr, cur.addr);
               chk("setup_pwrite", pwrite, cur.wr);
               chk("setup_pwdata", pwdata, cur.wdata);
               chk("setup_pstrb", pstrb, cur.strb);
            end
            acc = 0; pready = 1'($urandom); pslverr = 1'($urandom); prdata = $urandom;
         end else if (psel && penable) begin
            if (acc == 0) begin
               chk("penable_cycle", cyc, cur.setup_cyc + 1);
               pen_rise = cyc;
               if (plan_q.size() == 0) chk("access_no_plan", 32'd1, 32'd0);
               else pl = plan_q.pop_front();
            end else begin
               chk("access_paddr_stable", paddr, cur.addr);
               chk("access_ctrl_stable", {pwrite, pstrb}, {cur.wr, cur.strb});
               chk("access_pwdata_stable", pwdata, cur.wdata);
            end
            pready  = (acc == pl.w);
            pslverr = pready ? pl.err : 1'($urandom);
            prdata  = pready ? pl.rdata : $urandom;
            acc++;
         end else begin
            acc = 0; pready = 1'($urandom); pslverr = 1'($urandom); prdata = $urandom;
         end
      end
   end

   initial begin : rsp_ready_drv
      rsp_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (rr_mode)
            0:       rsp_ready = 1'b1;
            1:       rsp_ready = 1'($urandom);
            default: rsp_ready = 1'b0;
         endcase
      end
   end

   initial begin : monitor
      bit            seen;
      logic [31:0]   s_rdata;
      logic          s_err, s_tmo;
      exp_t          e;
      seen = 0; s_rdata = 0; s_err = 0; s_tmo = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            seen = 0;
         end else if (rsp_valid) begin
            chk("cmd_ready_low_in_resp", cmd_ready, 1'b0);
            chk("psel_low_in_resp", {psel, penable}, 2'b00);
            if (!seen) begin
               seen = 1; s_rdata = rsp_rdata; s_err = rsp_err; s_tmo = rsp_timeout;
               if (exp_q.size() == 0) chk("rsp_unexpected", 32'd1, 32'd0);
               else chk("rsp_latency", cyc - pen_rise, exp_q[0].lat);
            end else begin
               chk("rsp_stable", {rsp_rdata, rsp_err, rsp_timeout}, {s_rdata, s_err, s_tmo});
            end
            if (rsp_ready) begin
               if (exp_q.size() != 0) begin
                  e = exp_q.pop_front();
                  chk("rsp_rdata", rsp_rdata, e.rdata);
                  chk("rsp_err", rsp_err, e.err);
                  chk("rsp_timeout", rsp_timeout, e.tmo);
               end
               seen = 0;
            end
         end
      end
   end

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog actual=expired required=finish");
      $fatal(1);
   end

   initial begin : stim
      int n;
      rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_strb = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_apb", {psel, penable, pwrite, pstrb}, '0);
      chk("reset_paddr", paddr, 32'h0);
      chk("reset_pwdata", pwdata, 32'h0);
      chk("reset_rsp", {rsp_valid, rsp_err, rsp_timeout}, 3'b000);
      chk("reset_rsp_rdata", rsp_rdata, 32'h0);
      chk("reset_cmd_ready", cmd_ready, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;

      do_cmd(1'b1, 32'h0000_0010, 32'h1234_5678, 4'hF, mk(0, 1'b0, 32'hAAAA_5555));
      drain();
      do_cmd(1'b0, 32'h0000_0020, 32'h0, 4'h0, mk(3, 1'b0, 32'hDEAD_BEEF));
      drain();
      do_cmd(1'b1, 32'h0000_0044, 32'hCAFE_0001, 4'h5, mk(0, 1'b1, 32'h0));
      do_cmd(1'b0, 32'h0000_0048, 32'h0, 4'h0, mk(1, 1'b0, 32'h0BAD_F00D));
      drain();
      do_cmd(1'b0, 32'h0000_0080, 32'h0, 4'h0, mk(100, 1'b0, 32'h1111_2222));
      drain();

      rr_mode = 2;
      do_cmd(1'b1, 32'h0000_0013, 32'h5A5A_A5A5, 4'h3, mk(0, 1'b0, 32'h0));
      fork
         do_cmd(1'b0, 32'h0000_0104, 32'h0, 4'h0, mk(2, 1'b0, 32'h7654_3210));
         begin
            n = 0;
            while (!rsp_valid && n < 50) begin
               @(negedge clk);
               n++;
            end
            chk("stall_rsp_seen", rsp_valid, 1'b1);
            repeat (5) @(posedge clk);
            #1;
            rr_mode = 0;
         end
      join
      drain();

      do_cmd(1'b0, 32'h0000_0200, 32'h0, 4'h0, mk(3, 1'b0, 32'h3333_4444));
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("midrst_apb", {psel, penable, pwrite, pstrb}, '0);
      chk("midrst_paddr", paddr, 32'h0);
      chk("midrst_pwdata", pwdata, 32'h0);
      chk("midrst_rsp", {rsp_valid, rsp_err, rsp_timeout}, 3'b000);
      chk("midrst_rsp_rdata", rsp_rdata, 32'h0);
      exp_q.delete(); plan_q.delete(); apb_q.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("no_rsp_after_rst", rsp_valid, 1'b0);
      @(posedge clk);
      #1;
      do_cmd(1'b0, 32'h0000_0204, 32'h0, 4'h0, mk(0, 1'b0, 32'h9876_5432));
      drain();

      rr_mode = 1;
      for (int i = 0; i < 40; i++) begin
         do_cmd(1'($urandom), $urandom, $urandom, 4'($urandom),
                mk($urandom_range(0, 5), 1'($urandom), $urandom));
      end
      drain();
      rr_mode = 0;
      repeat (3) @(posedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
